vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Parametrised VGA raster timing generator, successor to the fixed 640x480 sync logic in top.
//   Divides clk into a pixel-enable strobe and runs horizontal/vertical counters.
//   Decodes active-low syncs, the active-video window and line/frame start pulses.
//   Blanks the pixel source outside the active window.
//   Sits between the board clock and the vga_hs_l/vga_vs_l/vga_rgb pins; pixel sources index by hcount/vcount.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch, pixels
//   H_SYNC    96   horizontal sync width, pixels
//   H_BP      48   horizontal back porch, pixels
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch, lines
//   V_SYNC    2    vertical sync width, lines
//   V_BP      33   vertical back porch, lines
//   CLK_DIV   2    clk cycles per pixel (>=1); 2 gives 25 MHz pixel rate from a 50 MHz clk
//   RGB_W     3    colour bus width
//   Derived:  H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise
//             HW=$clog2(H_TOTAL), VW=$clog2(V_TOTAL)
// PORTS
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous reset, active low
//   en           in   1      run enable; low freezes divider and counters
//   pattern_sel  in   1      select internal test pattern (VGA_PATTERN_EN only)
//   rgb_in       in   RGB_W  pixel colour for current (hcount,vcount)
//   pix_ce       out  1      one-clk pixel strobe; counters advance on this clk
//   hcount       out  HW     horizontal position, 0..H_TOTAL-1
//   vcount       out  VW     vertical position, 0..V_TOTAL-1
//   active       out  1      hcount<H_ACTIVE && vcount<V_ACTIVE
//   line_start   out  1      one-clk pulse: hcount wraps to 0
//   frame_start  out  1      one-clk pulse: (hcount,vcount) wraps to (0,0)
//   vga_hs_l     out  1      horizontal sync, active low
//   vga_vs_l     out  1      vertical sync, active low
//   vga_rgb      out  RGB_W  blanked colour output
// BEHAVIOUR
// - Reset (async, rst_n=0): divider=0, hcount=vcount=0, pix_ce=line_start=frame_start=0,
//   vga_hs_l=vga_vs_l=1, vga_rgb=0. Reset acts immediately, no clk edge needed. Restart from (0,0) after release.
// - Divider: counts 0..CLK_DIV-1 while en=1; pix_ce=1 for the clk where divider==CLK_DIV-1.
//   CLK_DIV=1: pix_ce=1 on every enabled clk.
// - On pix_ce: hcount+1. At hcount==H_TOTAL-1: hcount wraps to 0 and line_start=1.
//   On that same wrap, vcount+1; at vcount==V_TOTAL-1 it wraps to 0 and frame_start=1.
//   line_start and frame_start pulse coincident with pix_ce.
// - active: combinational from the hcount/vcount registers.
// - vga_hs_l=0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; vga_vs_l uses the V equivalent.
//   vga_rgb = active ? rgb_in : 0.
// - vga_hs_l, vga_vs_l and vga_rgb are registered every clk from the current counters and rgb_in.
//   They lag hcount/vcount by exactly 1 clk.
// - en=0: divider and counters hold; pix_ce, line_start and frame_start are 0.
//   Display outputs keep tracking the frozen counters. en is sampled per clk; resume continues from the held position.
// - Counter widths are fixed by HW/VW; no arithmetic exceeds H_TOTAL-1/V_TOTAL-1.
// CONFIGURATION
//   VGA_PATTERN_EN defined:
//     pattern_sel=1 replaces rgb_in with colour bars: bar=(hcount*8)/H_ACTIVE, colour=bar[RGB_W-1:0].
//     Blanking still applies. Bar changes with pattern_sel take effect on the next clk.
//   VGA_PATTERN_EN undefined: pattern_sel is ignored, no pattern logic.
// TESTING  (small geometry: H 8/2/3/3 => H_TOTAL=16, V 4/1/2/1 => V_TOTAL=8, CLK_DIV=2)
// - Reset: rst_n=0 -> hs_l=vs_l=1, vga_rgb=0, hcount=vcount=0, pix_ce=0, frame_start=0.
// - Free run, en=1: pix_ce every 2nd clk; hcount 0..15 then wraps; line=32 clk, frame=256 clk.
//   vga_hs_l low for hcount 10..12 (+1 clk); vga_vs_l low for vcount 5..6.
// - rgb_in=3'b111: vga_rgb=111 only for hcount<8 && vcount<4 (+1 clk), else 000.
//   frame_start once per 256 clk.
// - en=0 at hcount=5 for 10 clk: hcount holds 5, pix_ce=0; after en=1 the next pix_ce gives hcount=6.
// - rst_n=0 asynchronously at (12,2): outputs reach reset values before the next clk edge; first line after release starts at (0,0).
// - VGA_PATTERN_EN, pattern_sel=1, rgb_in=0: vga_rgb = hcount[2:0] over active pixels, 0 in blanking.
//   Without the macro: vga_rgb=rgb_in.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with registered syncs and blanking
// Optional colour-bar test pattern on pattern_sel: define VGA_PATTERN_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int RGB_W    = 3,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pattern_sel,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             pix_ce,
    output logic [HW-1:0]    hcount,
    output logic [VW-1:0]    vcount,
    output logic             active,
    output logic             line_start,
    output logic             frame_start,
    output logic             vga_hs_l,
    output logic             vga_vs_l,
    output logic [RGB_W-1:0] vga_rgb
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    logic [DW-1:0]    div_q, div_d;
    logic [HW-1:0]    hcount_q, hcount_d;
    logic [VW-1:0]    vcount_q, vcount_d;
    logic             hs_l_q, hs_l_d;
    logic             vs_l_q, vs_l_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [RGB_W-1:0] src_rgb;

    // rst_n gate keeps the strobe quiet in reset even when CLK_DIV=1
    always_comb begin
        pix_ce      = rst_n && en && (div_q == DIV_LAST);
        line_start  = pix_ce && (hcount_q == H_LAST);
        frame_start = line_start && (vcount_q == V_LAST);
        active      = (int'(hcount_q) < H_ACTIVE) && (int'(vcount_q) < V_ACTIVE);
    end

    always_comb begin
        div_d    = div_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        if (pix_ce) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

`ifdef VGA_PATTERN_EN
    always_comb begin
        src_rgb = pattern_sel ? RGB_W'((int'(hcount_q) * 8) / H_ACTIVE) : rgb_in;
    end
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
    always_comb begin
        src_rgb = rgb_in;
    end
`endif

    // display outputs follow the counters every clk, independent of en
    always_comb begin
        hs_l_d = !((int'(hcount_q) >= H_ACTIVE + H_FP) &&
                   (int'(hcount_q) <  H_ACTIVE + H_FP + H_SYNC));
        vs_l_d = !((int'(vcount_q) >= V_ACTIVE + V_FP) &&
                   (int'(vcount_q) <  V_ACTIVE + V_FP + V_SYNC));
        rgb_d  = active ? src_rgb : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            hs_l_q   <= 1'b1;
            vs_l_q   <= 1'b1;
            rgb_q    <= '0;
        end else begin
            div_q    <= div_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hs_l_q   <= hs_l_d;
            vs_l_q   <= vs_l_d;
            rgb_q    <= rgb_d;
        end
    end

    assign hcount   = hcount_q;
    assign vcount   = vcount_q;
    assign vga_hs_l = hs_l_q;
    assign vga_vs_l = vs_l_q;
    assign vga_rgb  = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a 16x8 raster with CLK_DIV=2
module tb_vga_timing_gen;
    localparam int H_TOTAL = 16;
    localparam int V_TOTAL = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       pattern_sel = 1'b0;
    logic [2:0] rgb_in = 3'b000;
    logic       pix_ce, active, line_start, frame_start, vga_hs_l, vga_vs_l;
    logic [3:0] hcount;
    logic [2:0] vcount;
    logic [2:0] vga_rgb;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .RGB_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel), .rgb_in(rgb_in),
        .pix_ce(pix_ce), .hcount(hcount), .vcount(vcount), .active(active),
        .line_start(line_start), .frame_start(frame_start),
        .vga_hs_l(vga_hs_l), .vga_vs_l(vga_vs_l), .vga_rgb(vga_rgb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pix_ce;
        logic       line_start;
        logic       frame_start;
        logic       active;
        logic       hs_l;
        logic       vs_l;
        logic [2:0] rgb;
        logic [3:0] h;
        logic [2:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_div, m_h, m_v;
    logic m_hs, m_vs;
    logic [2:0] m_rgb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div = 0; m_h = 0; m_v = 0;
        m_hs = 1'b1; m_vs = 1'b1; m_rgb = 3'b000;
    endtask

    function automatic logic [2:0] model_src();
`ifdef VGA_PATTERN_EN
        if (pattern_sel) return 3'(m_h % 8);
`endif
        return rgb_in;
    endfunction

    task automatic push_expect();
        exp_t e;
        e.pix_ce      = rst_n && en && (m_div == 1);
        e.line_start  = e.pix_ce && (m_h == H_TOTAL - 1);
        e.frame_start = e.line_start && (m_v == V_TOTAL - 1);
        e.active      = (m_h < 8) && (m_v < 4);
        e.hs_l        = m_hs;
        e.vs_l        = m_vs;
        e.rgb         = m_rgb;
        e.h           = 4'(m_h);
        e.v           = 3'(m_v);
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("pix_ce", 32'(pix_ce), 32'(e.pix_ce));
        chk("line_start", 32'(line_start), 32'(e.line_start));
        chk("frame_start", 32'(frame_start), 32'(e.frame_start));
        chk("active", 32'(active), 32'(e.active));
        chk("hs_l", 32'(vga_hs_l), 32'(e.hs_l));
        chk("vs_l", 32'(vga_vs_l), 32'(e.vs_l));
        chk("rgb", 32'(vga_rgb), 32'(e.rgb));
        chk("hcount", 32'(hcount), 32'(e.h));
        chk("vcount", 32'(vcount), 32'(e.v));
    endtask

    // advances the model across one rising edge using the inputs held this cycle
    task automatic model_edge();
        logic pce;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pce   = en && (m_div == 1);
        m_hs  = !(m_h >= 10 && m_h < 13);
        m_vs  = !(m_v >= 5 && m_v < 7);
        m_rgb = (m_h < 8 && m_v < 4) ? model_src() : 3'b000;
        if (en) m_div = (m_div == 1) ? 0 : m_div + 1;
        if (pce) begin
            if (m_h == H_TOTAL - 1) begin
                m_h = 0;
                m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
    endtask

    task automatic step();
        #1;
        push_expect();
        compare();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fs_cnt;
        int guard;
        #1;
        rst_n = 1'b0;
        en = 1'b1;
        rgb_in = 3'b111;
        model_reset();
        repeat (3) step();

        rst_n = 1'b1;
        fs_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (frame_start === 1'b1) fs_cnt++;
            step();
        end
        chk("frame_start_per_256", 32'(fs_cnt), 32'd1);
        for (int i = 0; i < 300; i++) begin
            rgb_in = 3'($urandom_range(0, 7));
            step();
        end

        pattern_sel = 1'b1;
        rgb_in = 3'b000;
        repeat (260) step();
        pattern_sel = 1'b0;
        rgb_in = 3'b101;

        guard = 0;
        while (!(m_h == 5 && m_div == 0) && guard < 600) begin
            step();
            guard++;
        end
        chk("reach_h5", 32'(m_h), 32'd5);
        en = 1'b0;
        repeat (10) step();
        chk("hold_hcount", 32'(hcount), 32'd5);
        chk("hold_pix_ce", 32'(pix_ce), 32'd0);
        en = 1'b1;
        guard = 0;
        while (hcount === 4'd5 && guard < 6) begin
            step();
            guard++;
        end
        chk("resume_hcount", 32'(hcount), 32'd6);

        guard = 0;
        while (!(m_h == 12 && m_v == 2) && guard < 600) begin
            step();
            guard++;
        end
        chk("reach_12_2", 32'(m_v * 16 + m_h), 32'd44);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_expect();
        compare();
        chk("async_hs_l", 32'(vga_hs_l), 32'd1);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
